// File: rtl/smi_frame_pkg.sv
// Shared SMI frame definitions: frame type identifier bytes and the
// request-splitter state encoding.
package smi_frame_pkg;

  localparam int unsigned EofcWidth   = 8;
  localparam int unsigned TypeIdWidth = 8;

  localparam logic [TypeIdWidth-1:0] READ_REQ_ID_BYTE   = 8'h01;
  localparam logic [TypeIdWidth-1:0] WRITE_REQ_ID_BYTE  = 8'h02;
  localparam logic [TypeIdWidth-1:0] WRITE_RESP_ID_BYTE = 8'h03;

  typedef enum logic [1:0] {
    Idle,
    FwdRd,
    FwdWr,
    Drop
  } splitStateT;

endpackage

// File: rtl/smi_flit_out_reg.sv
// One-entry registered SMI output buffer; holds a flit until the
// downstream stage takes it with Stop low.
module smi_flit_out_reg
  import smi_frame_pkg::*;
#(
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 srstN,
  input  logic                 load,
  input  logic [EofcWidth-1:0] loadEofc,
  input  logic [DataWidth-1:0] loadData,
  input  logic                 stop,
  output logic                 ready,
  output logic [EofcWidth-1:0] eofc,
  output logic [DataWidth-1:0] data
);

  // A load wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (!srstN) begin
      ready <= 1'b0;
    end else if (load) begin
      ready <= 1'b1;
    end else if (ready && !stop) begin
      ready <= 1'b0;
    end
  end

  // Payload is only meaningful while ready is high, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      eofc <= loadEofc;
      data <= loadData;
    end
  end

endmodule

// File: rtl/smi_request_type_splitter.sv
// Routes whole SMI request frames to read or write outputs by header type byte.
// Optional SMI_SPLITTER_DROP_COUNT_EN adds a saturating discarded-frame counter.
module smi_request_type_splitter
  import smi_frame_pkg::*;
#(
  parameter  int unsigned DataIndexSize = 3,
  localparam int unsigned DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                 clk,
  input  logic                 srstN,
  input  logic                 smiInReady,
  input  logic [EofcWidth-1:0] smiInEofc,
  input  logic [DataWidth-1:0] smiInData,
  output logic                 smiInStop,
  output logic                 smiRdReady,
  output logic [EofcWidth-1:0] smiRdEofc,
  output logic [DataWidth-1:0] smiRdData,
  input  logic                 smiRdStop,
  output logic                 smiWrReady,
  output logic [EofcWidth-1:0] smiWrEofc,
  output logic [DataWidth-1:0] smiWrData,
  input  logic                 smiWrStop,
  output logic [15:0]          dropCount
);

  splitStateT state;
  logic       isRdHdr;
  logic       isWrHdr;
  logic       routeRd;
  logic       routeWr;
  logic       inAccept;
  logic       lastFlit;

  assign isRdHdr  = (smiInData[TypeIdWidth-1:0] == READ_REQ_ID_BYTE);
  assign isWrHdr  = (smiInData[TypeIdWidth-1:0] == WRITE_REQ_ID_BYTE);
  assign lastFlit = (smiInEofc != 8'd0);

  // Current destination: decoded from the header in Idle, latched by state otherwise.
  always_comb begin
    routeRd = 1'b0;
    routeWr = 1'b0;
    case (state)
      Idle:    begin
        routeRd = isRdHdr;
        routeWr = isWrHdr;
      end
      FwdRd:   routeRd = 1'b1;
      FwdWr:   routeWr = 1'b1;
      default: ;
    endcase
  end

  // Only a full, stopped target buffer stalls upstream; discards never stall.
  assign smiInStop = (routeRd && smiRdReady && smiRdStop) ||
                     (routeWr && smiWrReady && smiWrStop);
  assign inAccept  = smiInReady && !smiInStop;

  always_ff @(posedge clk) begin
    if (!srstN) begin
      state <= Idle;
    end else if (inAccept) begin
      case (state)
        Idle: begin
          if (!lastFlit) begin
            if (isRdHdr)      state <= FwdRd;
            else if (isWrHdr) state <= FwdWr;
            else              state <= Drop;
          end
        end
        default: begin
          if (lastFlit) state <= Idle;
        end
      endcase
    end
  end

  smi_flit_out_reg #(
    .DataWidth(DataWidth)
  ) uRdOut (
    .clk      (clk),
    .srstN    (srstN),
    .load     (inAccept && routeRd),
    .loadEofc (smiInEofc),
    .loadData (smiInData),
    .stop     (smiRdStop),
    .ready    (smiRdReady),
    .eofc     (smiRdEofc),
    .data     (smiRdData)
  );

  smi_flit_out_reg #(
    .DataWidth(DataWidth)
  ) uWrOut (
    .clk      (clk),
    .srstN    (srstN),
    .load     (inAccept && routeWr),
    .loadEofc (smiInEofc),
    .loadData (smiInData),
    .stop     (smiWrStop),
    .ready    (smiWrReady),
    .eofc     (smiWrEofc),
    .data     (smiWrData)
  );

`ifdef SMI_SPLITTER_DROP_COUNT_EN
  logic [15:0] dropCountQ;

  // Counts accepted headers of unknown frames, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!srstN) begin
      dropCountQ <= 16'd0;
    end else if (inAccept && (state == Idle) && !isRdHdr && !isWrHdr &&
                 (dropCountQ != 16'hFFFF)) begin
      dropCountQ <= dropCountQ + 16'd1;
    end
  end

  assign dropCount = dropCountQ;
`else
  assign dropCount = 16'd0;
`endif

endmodule

// File: tb/tb_smi_request_type_splitter.sv
// Self-checking bench for smi_request_type_splitter: frame-level queue model
// compared every cycle, plus directed literal checks.
module tb_smi_request_type_splitter;

  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [7:0]           eofc;
    logic [DataWidth-1:0] data;
  } flitT;

  logic                 clk = 1'b0;
  logic                 srstN = 1'b0;
  logic                 smiInReady = 1'b0;
  logic [7:0]           smiInEofc = 8'd0;
  logic [DataWidth-1:0] smiInData = '0;
  logic                 smiInStop;
  logic                 smiRdReady;
  logic [7:0]           smiRdEofc;
  logic [DataWidth-1:0] smiRdData;
  logic                 smiRdStop = 1'b0;
  logic                 smiWrReady;
  logic [7:0]           smiWrEofc;
  logic [DataWidth-1:0] smiWrData;
  logic                 smiWrStop = 1'b0;
  logic [15:0]          dropCount;

  always #5 clk = ~clk;

  smi_request_type_splitter #(.DataIndexSize(3)) dut (
    .clk        (clk),
    .srstN      (srstN),
    .smiInReady (smiInReady),
    .smiInEofc  (smiInEofc),
    .smiInData  (smiInData),
    .smiInStop  (smiInStop),
    .smiRdReady (smiRdReady),
    .smiRdEofc  (smiRdEofc),
    .smiRdData  (smiRdData),
    .smiRdStop  (smiRdStop),
    .smiWrReady (smiWrReady),
    .smiWrEofc  (smiWrEofc),
    .smiWrData  (smiWrData),
    .smiWrStop  (smiWrStop),
    .dropCount  (dropCount)
  );

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int wrStopFrom  = -100;
  bit checkEn     = 1'b0;

  // Model state: pending flit per output, current frame destination, drop tally.
  flitT rdQ[$];
  flitT wrQ[$];
  bit   inFrame    = 1'b0;
  int   curDest    = 0;
  int   modelDrops = 0;

  function automatic int decode(input logic [7:0] b);
    if (b == 8'h01) return 1;
    if (b == 8'h02) return 2;
    return 0;
  endfunction

  function automatic int flitDest();
    return inFrame ? curDest : decode(smiInData[7:0]);
  endfunction

  function automatic bit modelStop();
    int d;
    d = flitDest();
    return ((d == 1) && (rdQ.size() != 0) && (smiRdStop == 1'b1)) ||
           ((d == 2) && (wrQ.size() != 0) && (smiWrStop == 1'b1));
  endfunction

  function automatic logic [15:0] expDrops();
`ifdef SMI_SPLITTER_DROP_COUNT_EN
    return 16'(modelDrops);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write-side backpressure window, armed by the stimulus via wrStopFrom.
  always @(posedge clk) begin
    #1;
    smiWrStop = (cyc >= wrStopFrom) && (cyc < wrStopFrom + 3);
  end

  // Frame-level model, advanced on each active edge from pre-edge inputs.
  always @(posedge clk) begin
    int   d;
    bit   acc;
    flitT f;
    if (!srstN) begin
      rdQ.delete();
      wrQ.delete();
      inFrame    = 1'b0;
      curDest    = 0;
      modelDrops = 0;
    end else begin
      acc = (smiInReady == 1'b1) && !modelStop();
      d   = flitDest();
      if ((rdQ.size() != 0) && (smiRdStop == 1'b0)) void'(rdQ.pop_front());
      if ((wrQ.size() != 0) && (smiWrStop == 1'b0)) void'(wrQ.pop_front());
      if (acc) begin
        f.eofc = smiInEofc;
        f.data = smiInData;
        if (d == 1) rdQ.push_back(f);
        if (d == 2) wrQ.push_back(f);
        if (!inFrame) begin
          if ((d == 0) && (modelDrops < 65535)) modelDrops++;
          if (smiInEofc == 8'd0) begin
            inFrame = 1'b1;
            curDest = d;
          end
        end else if (smiInEofc != 8'd0) begin
          inFrame = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      check("rdReady", 64'(smiRdReady), 64'(rdQ.size() != 0));
      if (rdQ.size() != 0) begin
        check("rdData", 64'(smiRdData), 64'(rdQ[0].data));
        check("rdEofc", 64'(smiRdEofc), 64'(rdQ[0].eofc));
      end
      check("wrReady", 64'(smiWrReady), 64'(wrQ.size() != 0));
      if (wrQ.size() != 0) begin
        check("wrData", 64'(smiWrData), 64'(wrQ[0].data));
        check("wrEofc", 64'(smiWrEofc), 64'(wrQ[0].eofc));
      end
      check("inStop", 64'(smiInStop), 64'(modelStop()));
      check("dropCount", 64'(dropCount), 64'(expDrops()));
    end
  end

  // Presents one flit and returns #1 after the edge that accepts it.
  task automatic sendFlit(input logic [7:0] e, input logic [DataWidth-1:0] d);
    int   waitCyc;
    logic stopSeen;
    waitCyc    = 0;
    smiInReady = 1'b1;
    smiInEofc  = e;
    smiInData  = d;
    do begin
      @(negedge clk);
      stopSeen = smiInStop;
      @(posedge clk);
      waitCyc++;
    end while ((stopSeen !== 1'b0) && (waitCyc < 60));
    if (stopSeen !== 1'b0) check("acceptTimeout", 64'(stopSeen), 64'd0);
    #1;
    smiInReady = 1'b0;
  endtask

  task automatic idle(input int n);
    smiInReady = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    srstN   = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);
    check("resetRdReady", 64'(smiRdReady), 64'd0);
    check("resetWrReady", 64'(smiWrReady), 64'd0);
    check("resetDrop", 64'(dropCount), 64'd0);
    @(posedge clk);
    #1;

    // Single-flit read
    sendFlit(8'd4, 64'h1122_3344_5566_7701);
    @(negedge clk);
    check("rdSingleReady", 64'(smiRdReady), 64'd1);
    check("rdSingleData", 64'(smiRdData), 64'h1122_3344_5566_7701);
    check("rdSingleEofc", 64'(smiRdEofc), 64'd4);
    check("rdSingleWrIdle", 64'(smiWrReady), 64'd0);
    @(posedge clk);
    #1;
    idle(2);

    // Four-flit write with a 3-cycle stall while flit 2 is buffered
    sendFlit(8'd0, 64'hA0A0_A0A0_A0A0_A002);
    sendFlit(8'd0, 64'hB1B1_B1B1_B1B1_B1B1);
    wrStopFrom = cyc + 1;
    sendFlit(8'd0, 64'hC2C2_C2C2_C2C2_C2C2);
    @(negedge clk);
    check("wrStallStop", 64'(smiInStop), 64'd1);
    @(posedge clk);
    #1;
    sendFlit(8'd8, 64'hD3D3_D3D3_D3D3_D3D3);
    idle(3);

    // Unknown type, three flits
    sendFlit(8'd0, 64'h0000_0000_0000_007F);
    sendFlit(8'd0, 64'h0000_0000_0000_0001);
    sendFlit(8'd3, 64'h0000_0000_0000_0002);
    idle(1);
    @(negedge clk);
`ifdef SMI_SPLITTER_DROP_COUNT_EN
    check("dropOne", 64'(dropCount), 64'd1);
`else
    check("dropOne", 64'(dropCount), 64'd0);
`endif
    check("dropNoRd", 64'(smiRdReady), 64'd0);
    check("dropNoWr", 64'(smiWrReady), 64'd0);
    @(posedge clk);
    #1;

    // Read then write back to back with the read output stuck
    smiRdStop = 1'b1;
    fork
      begin
        sendFlit(8'd0, 64'h0101_0101_0101_0101);
        sendFlit(8'd8, 64'h0202_0202_0202_0202);
        sendFlit(8'd0, 64'h0303_0303_0303_0302);
        sendFlit(8'd5, 64'h0404_0404_0404_0404);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        smiRdStop = 1'b0;
      end
    join
    idle(3);

    // Reset in the middle of a write frame
    sendFlit(8'd0, 64'hEEEE_EEEE_EEEE_EE02);
    sendFlit(8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    srstN = 1'b0;
    @(posedge clk);
    #1;
    srstN = 1'b1;
    @(negedge clk);
    check("rstRdReady", 64'(smiRdReady), 64'd0);
    check("rstWrReady", 64'(smiWrReady), 64'd0);
    @(posedge clk);
    #1;
    sendFlit(8'd2, 64'h5555_6666_7777_8801);
    @(negedge clk);
    check("rstNextRd", 64'(smiRdData), 64'h5555_6666_7777_8801);
    check("rstNextWrIdle", 64'(smiWrReady), 64'd0);
    @(posedge clk);
    #1;

    // Drop counter saturation
    for (int i = 0; i < 65537; i++) sendFlit(8'd1, 64'h0000_0000_0000_007F);
    idle(1);
    @(negedge clk);
`ifdef SMI_SPLITTER_DROP_COUNT_EN
    check("dropSat", 64'(dropCount), 64'hFFFF);
`else
    check("dropSat", 64'(dropCount), 64'd0);
`endif
    @(posedge clk);
    #1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
